// File: rtl/spi_xfer_pkg.sv
// spi_xfer_pkg: shared state encoding and sizing constants for the SPI transfer engine.
package spi_xfer_pkg;
  localparam int MAX_LEN = 32;
  localparam int LEN_W = 6;
  typedef enum logic [2:0] {IDLE, SETUP, LOAD, LOW, HIGH, HOLD, PAUSE} state_t;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/spi_half_timer.sv
// spi_half_timer: down-counter timing SPI half-periods and chip-select setup/hold windows.
module spi_half_timer
  import spi_xfer_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val - W'(1);
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign expire = cnt == '0;
endmodule

// File: rtl/spi_xfer_engine.sv
// spi_xfer_engine: byte-stream SPI mode 3 master with burst framing and optional chip-select continuation.
module spi_xfer_engine
  import spi_xfer_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] len,
  input  logic       keep_cs,
  input  logic       abort,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       spi_clk,
  output logic       spi_csn,
  output logic       spi_mosi,
  input  logic       spi_miso
);
  localparam int TW = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD) + 1);
  state_t state, state_n;
  logic [LEN_W-1:0] len_q, byte_cnt;
  logic keep_q, exp_t, go, last, byte_end;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sh, rx_sh;
  logic [TW-1:0] tval;
  assign go = start && len != '0;
  assign last = byte_cnt + LEN_W'(1) == len_q;
  assign byte_end = state == HIGH && exp_t && bit_cnt == 3'd7;
  assign tx_ready = state == LOAD;
  assign busy = state != IDLE && state != PAUSE;
  assign spi_csn = state == IDLE;
  assign spi_clk = state != LOW;
  assign tval = state_n == SETUP ? TW'(CS_SETUP) : state_n == HOLD ? TW'(CS_HOLD) : TW'(CLK_DIV);
  spi_half_timer #(.W(TW)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(state_n != state),
    .load_val(tval),
    .expire(exp_t)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (go) state_n = SETUP;
      SETUP:   if (exp_t) state_n = LOAD;
      LOAD:    if (tx_valid) state_n = LOW;
      LOW:     if (exp_t) state_n = HIGH;
      HIGH:    if (exp_t) state_n = bit_cnt != 3'd7 ? LOW : !last ? LOAD : keep_q ? PAUSE : HOLD;
      HOLD:    if (exp_t) state_n = IDLE;
      PAUSE:   if (go) state_n = LOAD; else if (start && !keep_cs) state_n = HOLD;
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      len_q <= '0;
      keep_q <= 1'b0;
      byte_cnt <= '0;
      bit_cnt <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      spi_mosi <= 1'b0;
      rx_valid <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      rx_valid <= byte_end && !abort;
      // PAUSE entry carries the final rx strobe, so done trails it by one cycle
      done <= !abort && ((state == HOLD && exp_t) || (state == PAUSE && rx_valid));
      overrun <= start && busy;
      if (go && (state == IDLE || state == PAUSE)) begin
        len_q <= len;
        keep_q <= keep_cs;
        byte_cnt <= '0;
      end
      if (state == LOAD && state_n == LOW) begin
        tx_sh <= tx_data;
        spi_mosi <= tx_data[7];
        bit_cnt <= '0;
      end
      if (state == LOW && exp_t) rx_sh <= {rx_sh[6:0], spi_miso};
      if (state == HIGH && state_n == LOW) begin
        tx_sh <= tx_sh << 1;
        spi_mosi <= tx_sh[6];
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_end) begin
        rx_data <= rx_sh;
        byte_cnt <= byte_cnt + LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_spi_xfer_engine.sv
// tb_spi_xfer_engine: table-driven and randomized bursts checked against a pin-level SPI model.
module tb_spi_xfer_engine;
  localparam int CLK_DIV = 1, CS_SETUP = 1, CS_HOLD = 1;
  localparam int BYTE_T = 16 * CLK_DIV + 1;
  logic clk = 0, reset = 1, start = 0, keep_cs = 0, abort = 0, tx_valid = 0;
  logic [5:0] len = 0;
  logic [7:0] tx_data = 0;
  logic tx_ready, rx_valid, busy, done, overrun, spi_clk, spi_csn, spi_mosi, spi_miso;
  logic [7:0] rx_data;
  spi_xfer_engine #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .keep_cs(keep_cs), .abort(abort),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .busy(busy), .done(done), .overrun(overrun), .spi_clk(spi_clk),
    .spi_csn(spi_csn), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  // tx source: test appends to tx_mem, driver presents bytes in order
  logic [7:0] tx_mem[256];
  int tx_wr = 0, tx_rd = 0;
  logic hs = 0;
  always @(negedge clk) hs = tx_valid && tx_ready;
  always @(posedge clk) begin
    #1;
    if (hs) tx_rd = tx_rd + 1;
    tx_valid = tx_rd != tx_wr;
    tx_data = tx_valid ? tx_mem[tx_rd & 255] : 8'h00;
  end
  // flash model: loopback or fixed response byte, MSB first
  logic lb = 1;
  logic [7:0] resp = 0;
  logic miso_bit = 0;
  assign spi_miso = lb ? spi_mosi : miso_bit;
  int cyc = 0, rx_n = 0, done_n = 0, ovr_n = 0, rise_n = 0, mosi_n = 0, nb = 0;
  int csn_rise = 0, rise_done = 0, low_len = 0, last_low = 0, done_cyc = 0;
  int v_rx = 0, v_done = 0, v_mosi = 0, v_rdy = 0;
  int rx_cyc[256];
  logic [7:0] rx_log[256], mosi_log[256], msh = 0;
  logic p_rx = 0, p_done = 0, p_mosi = 0, p_clk = 1, p_csn = 1, p_rst = 1;
  always @(negedge clk) begin
    cyc++;
    if (rx_valid) begin
      rx_log[rx_n & 255] = rx_data;
      rx_cyc[rx_n & 255] = cyc;
      rx_n++;
    end
    if (rx_valid && p_rx) v_rx++;
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (done && p_done) v_done++;
    if (overrun) ovr_n++;
    if (tx_ready && (spi_csn || !spi_clk)) v_rdy++;
    if (spi_mosi !== p_mosi && !p_rst && !(p_clk && !spi_clk)) v_mosi++;
    if (!p_clk && spi_clk && !spi_csn) begin
      rise_n++;
      msh = {msh[6:0], spi_mosi};
      nb++;
      if (nb == 8) begin
        mosi_log[mosi_n & 255] = msh;
        mosi_n++;
        nb = 0;
      end
    end
    if (spi_csn) nb = 0;
    if (!spi_csn) low_len++;
    if (!p_csn && spi_csn) begin
      csn_rise++;
      last_low = low_len;
      low_len = 0;
      if (done) rise_done++;
    end
    miso_bit = resp[7-nb];
    p_rx = rx_valid; p_done = done; p_mosi = spi_mosi; p_clk = spi_clk; p_csn = spi_csn; p_rst = reset;
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic pulse(input int n, input logic k);
    @(posedge clk);
    #1 start = 1; len = 6'(n); keep_cs = k;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic run_burst(input int n, input logic k, input logic cont, input logic l, input logic [7:0] r,
                           input int gap_at, input int ovr_at, input logic [7:0] base, input logic rnd);
    logic [7:0] txb[32];
    logic ok;
    int rx0, m0, d0, o0, cr0, rd0, r0, ff, t, pushed;
    rx0 = rx_n; m0 = mosi_n; d0 = done_n; o0 = ovr_n; cr0 = csn_rise; rd0 = rise_done; r0 = rise_n;
    lb = l; resp = r;
    pushed = gap_at != 0 ? gap_at : n;
    for (int i = 0; i < n; i++) txb[i] = rnd ? 8'($urandom) : base + 8'(i);
    for (int i = 0; i < pushed; i++) begin tx_mem[tx_wr & 255] = txb[i]; tx_wr++; end
    pulse(n, k);
    ff = 0;
    do begin tick(); ff++; end while (spi_clk && ff < 100);
    chk("first_fall", ff, cont ? 2 : CS_SETUP + 2);
    if (ovr_at != 0) begin
      repeat (ovr_at) tick();
      pulse(5, 0);
    end
    if (gap_at != 0) begin
      t = 0;
      while (!(tx_ready && tx_rd == tx_wr) && t < 2000) begin tick(); t++; end
      ok = t < 2000;
      repeat (10) begin tick(); ok &= tx_ready && spi_clk && !spi_csn; end
      chk("gap_hold", ok, 1);
      for (int i = gap_at; i < n; i++) begin tx_mem[tx_wr & 255] = txb[i]; tx_wr++; end
    end
    t = 0;
    while (done_n == d0 && t < 4000) begin tick(); t++; end
    chk("done_seen", done_n != d0, 1);
    repeat (4) tick();
    chk("rx_count", rx_n - rx0, n);
    chk("clk_pulses", rise_n - r0, 8 * n);
    for (int i = 0; i < n; i++) begin
      chk("rx_byte", rx_log[(rx0 + i) & 255], l ? txb[i] : r);
      chk("mosi_byte", mosi_log[(m0 + i) & 255], txb[i]);
      if (i > 0 && gap_at == 0) chk("byte_period", rx_cyc[(rx0 + i) & 255] - rx_cyc[(rx0 + i - 1) & 255], BYTE_T);
    end
    chk("done_once", done_n - d0, 1);
    chk("overrun", ovr_n - o0, ovr_at != 0);
    if (k) begin
      chk("pause_csn", spi_csn, 0);
      chk("pause_busy", busy, 0);
      chk("pause_csn_rise", csn_rise - cr0, 0);
      chk("pause_done_lag", done_cyc - rx_cyc[(rx0 + n - 1) & 255], 1);
    end else begin
      chk("csn_rise", csn_rise - cr0, 1);
      chk("done_at_csn_rise", rise_done - rd0, 1);
      if (!cont && gap_at == 0) chk("csn_low_len", last_low, CS_SETUP + n * BYTE_T + CS_HOLD);
    end
  endtask
  task automatic stop_test(input logic use_reset);
    int r0, rx0, d0, t;
    lb = 1;
    tx_mem[tx_wr & 255] = 8'hA5; tx_wr++;
    pulse(1, 0);
    r0 = rise_n;
    t = 0;
    while (!(rise_n - r0 == 4 && !spi_clk) && t < 200) begin tick(); t++; end
    chk("reach_bit5", t < 200, 1);
    rx0 = rx_n; d0 = done_n;
    if (use_reset) reset = 1; else abort = 1;
    @(posedge clk);
    #1 reset = 0; abort = 0;
    tick();
    chk("stop_csn", spi_csn, 1);
    chk("stop_clk", spi_clk, 1);
    chk("stop_busy", busy, 0);
    chk("stop_rx_valid", rx_valid, 0);
    chk("stop_done", done, 0);
    if (use_reset) begin
      chk("rst_mosi", spi_mosi, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_tx_ready", tx_ready, 0);
    end
    repeat (30) tick();
    chk("stop_no_rx", rx_n - rx0, 0);
    chk("stop_no_done", done_n - d0, 0);
    tx_wr = tx_rd;
    run_burst(1, 0, 0, 0, 8'h3C, 0, 0, 8'hE7, 0);
  endtask
  typedef struct {
    int n; logic k; logic l; logic [7:0] r; int gap; int ovr; logic [7:0] base;
  } vec_t;
  initial begin
    vec_t tbl[6];
    logic cont;
    int n;
    logic k, l;
    tbl[0] = '{1, 0, 0, 8'hC2, 0, 0, 8'h9F};
    tbl[1] = '{32, 0, 1, 8'h00, 0, 0, 8'h00};
    tbl[2] = '{4, 0, 1, 8'h00, 2, 0, 8'h40};
    tbl[3] = '{3, 1, 1, 8'h00, 0, 0, 8'hA0};
    tbl[4] = '{2, 0, 0, 8'h5A, 0, 0, 8'h10};
    tbl[5] = '{2, 0, 1, 8'h00, 0, 6, 8'h30};
    repeat (3) @(posedge clk);
    #1 reset = 0;
    tick();
    chk("rst_spi_clk", spi_clk, 1);
    chk("rst_spi_csn", spi_csn, 1);
    chk("rst_spi_mosi", spi_mosi, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 0);
    cont = 0;
    for (int i = 0; i < 6; i++) begin
      run_burst(tbl[i].n, tbl[i].k, cont, tbl[i].l, tbl[i].r, tbl[i].gap, tbl[i].ovr, tbl[i].base, 0);
      cont = tbl[i].k;
    end
    for (int i = 0; i < 8; i++) begin
      n = int'($urandom_range(1, 6));
      k = i < 7 ? 1'($urandom_range(0, 1)) : 1'b0;
      l = 1'($urandom_range(0, 1));
      run_burst(n, k, cont, l, 8'($urandom), 0, 0, 8'h00, 1);
      cont = k;
    end
    stop_test(0);
    stop_test(1);
    chk("rx_valid_single", v_rx, 0);
    chk("done_single", v_done, 0);
    chk("mosi_on_fall", v_mosi, 0);
    chk("tx_ready_in_load", v_rdy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
